ex_div_unit: RTL and testbench
==============================

// Module: ex_div_unit
// PURPOSE
//  Iterative integer divider for the RV32M DIV/DIVU/REM/REMU ops in the Execute stage.
//  Consumes the Execute-side operands and funct3 out of the D->E pipeline register.
//  Drives a stall back to the hazard logic, which freezes the fetch/decode/D->E registers
//  while a division runs. Delivers a one-cycle-valid result to the E-stage result mux.
// PARAMETERS
//  XLEN            32  operand/result width
//  BITS_PER_CYCLE  1   quotient bits retired per RUN cycle; legal 1,2,4 (must divide XLEN)
// PORTS
//  clk         in   1     clock, rising edge
//  rst         in   1     asynchronous, active-high reset
//  DivStartE   in   1     E-stage instr is a divide op (decoder DivD, registered to E)
//  FlushE      in   1     E-stage flush (branch/jump redirect); aborts any division
//  funct3E     in   3     100 DIV, 101 DIVU, 110 REM, 111 REMU
//  rs1E        in   XLEN  dividend
//  rs2E        in   XLEN  divisor
//  DivStallE   out  1     hold F/D/E pipeline registers this cycle
//  DivDoneE    out  1     DivResultE valid this cycle (single-cycle pulse)
//  DivResultE  out  XLEN  quotient or remainder, per funct3
// BEHAVIOUR
//  Reset: state=IDLE; DivStallE=0, DivDoneE=0, DivResultE=0; internal regs cleared.
//   rst asserted mid-RUN aborts immediately. No result is produced.
//  FSM states: IDLE, RUN, DONE.
//  IDLE
//   - Start accepted when DivStartE & funct3E[2] & ~FlushE.
//   - DivStartE with funct3E[2]=0 is ignored.
//   - On accept, latch operands, funct3 and sign info. DivStallE=1 combinationally in
//     the accept cycle.
//   - Next state: DONE if fast path, else RUN.
//  Fast path (no iteration)
//   - Divisor==0: quotient = all ones (DIV and DIVU); remainder = dividend.
//   - Overflow (DIV/REM with rs1=0x8000_0000, rs2=0xFFFF_FFFF): quotient=0x8000_0000,
//     remainder=0.
//  RUN
//   - Radix-2^BITS_PER_CYCLE restoring division on magnitudes.
//   - Signed ops take abs() of the operands at accept. An unsigned (XLEN+1)-bit partial
//     remainder prevents overflow of |0x8000_0000|.
//   - Runs exactly XLEN/BITS_PER_CYCLE cycles (32 at default). Iteration counter
//     wraps to 0, then DONE.
//   - DivStallE=1 in every RUN cycle.
//  DONE (one cycle)
//   - DivStallE=0, DivDoneE=1, DivResultE registered and valid. Always -> IDLE.
//   - DivStartE seen during DONE is ignored: it still belongs to the same instr. That
//     instr leaves E at this edge; the next divide is accepted from IDLE.
//  Sign fixup for DIV/REM
//   - Quotient negated iff operand signs differ; remainder takes the dividend's sign.
//   - Invariant: dividend = q*divisor + r.
//  Latency
//   - Normal op: accept + 32 RUN + DONE = 34 cycles in E; stall asserted in 33 of them.
//   - Fast path: 2 cycles (accept, DONE).
//  DivResultE holds its last value outside DONE. Consumers qualify it with DivDoneE.
//  FlushE in RUN or DONE: next state IDLE, DivDoneE forced 0 that cycle, DivStallE=0
//   that cycle. FlushE wins over DivStartE.
//  Operand inputs may change after accept. Only latched copies are used.
// TESTING
//  1 DIV 100/7: start pulse -> DivStallE high 33 cycles, DivDoneE 1 cycle later,
//    DivResultE=14; REM same operands -> 2.
//  2 Signs: DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1);
//    REMU 0xFFFFFFF9/2 -> 1.
//  3 Divide by zero: DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5. Each DONE on the 2nd cycle,
//    stall for 1 cycle only.
//  4 Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; 2-cycle fast path.
//  5 Abort: FlushE at RUN cycle 10 -> IDLE next cycle, no DivDoneE. A following DIVU
//    20/3 -> 6 with full 34-cycle latency.
//  6 Async rst mid-RUN (asserted off-edge) -> all outputs 0 immediately. After release,
//    a new DIV 9/3 -> 3.

Source files
------------

// File: rtl/ex_div_unit.sv
// Iterative RV32M divider for the Execute stage: DIV/DIVU/REM/REMU with a radix-2^k restoring core.
// Stalls the front of the pipeline while iterating and pulses a one-cycle result valid.
module ex_div_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            DivStartE,
  input  logic            FlushE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] rs1E,
  input  logic [XLEN-1:0] rs2E,
  output logic            DivStallE,
  output logic            DivDoneE,
  output logic [XLEN-1:0] DivResultE
);

  localparam int unsigned STEPS = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = XLEN'(1) << (XLEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN:0]    rem_q;
  logic [XLEN-1:0]  quo_q, dvs_q, result_q;
  logic             neg_quo_q, neg_rem_q, sel_rem_q;

  logic             accept, is_signed, div_zero, overflow, fast, last_step;
  logic [XLEN-1:0]  mag1, mag2, fast_res;
  logic [XLEN:0]    step_rem, trial;
  logic [XLEN-1:0]  step_quo, quo_fix, rem_fix;

  assign is_signed = ~funct3E[0];
  assign accept    = (state_q == S_IDLE) & DivStartE & funct3E[2] & ~FlushE;
  assign div_zero  = (rs2E == '0);
  assign overflow  = is_signed & (rs1E == MIN_NEG) & (rs2E == '1);
  assign fast      = div_zero | overflow;
  assign last_step = (cnt_q == CNT_LAST);

  // Magnitudes; |MIN_NEG| wraps to itself, which is the correct unsigned magnitude.
  assign mag1 = (is_signed & rs1E[XLEN-1]) ? -rs1E : rs1E;
  assign mag2 = (is_signed & rs2E[XLEN-1]) ? -rs2E : rs2E;

  always_comb begin
    fast_res = '0;
    if (div_zero) fast_res = funct3E[1] ? rs1E : '1;
    else          fast_res = funct3E[1] ? '0 : MIN_NEG;
  end

  // BITS_PER_CYCLE restoring steps; the extra remainder bit absorbs the shift-in.
  always_comb begin
    step_rem = rem_q;
    step_quo = quo_q;
    trial    = '0;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      trial    = {step_rem[XLEN-1:0], step_quo[XLEN-1]};
      step_quo = {step_quo[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, dvs_q}) begin
        trial       = trial - {1'b0, dvs_q};
        step_quo[0] = 1'b1;
      end
      step_rem = trial;
    end
  end

  assign quo_fix = neg_quo_q ? -step_quo : step_quo;
  assign rem_fix = neg_rem_q ? -step_rem[XLEN-1:0] : step_rem[XLEN-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    DivStallE = 1'b0;
    DivDoneE  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          DivStallE = 1'b1;
          state_d   = fast ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (FlushE) begin
          state_d = S_IDLE;
        end else begin
          DivStallE = 1'b1;
          if (last_step) state_d = S_DONE;
        end
      end
      S_DONE: begin
        DivDoneE = ~FlushE;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latch at accept, iteration in RUN, result capture on fast path or last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
    end else if (accept) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= mag1;
      dvs_q     <= mag2;
      neg_quo_q <= is_signed & (rs1E[XLEN-1] ^ rs2E[XLEN-1]);
      neg_rem_q <= is_signed & rs1E[XLEN-1];
      sel_rem_q <= funct3E[1];
      if (fast) result_q <= fast_res;
    end else if (state_q == S_RUN) begin
      rem_q <= step_rem;
      quo_q <= step_quo;
      cnt_q <= last_step ? '0 : cnt_q + CNT_W'(1);
      if (last_step && !FlushE) result_q <= sel_rem_q ? rem_fix : quo_fix;
    end
  end

  assign DivResultE = result_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed RV32M cases, flush/reset aborts and random ops
// compared against a plain-arithmetic reference model.
module tb_ex_div_unit;

  localparam int unsigned RUN_CYCLES = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        DivStartE = 1'b0;
  logic        FlushE = 1'b0;
  logic [2:0]  funct3E = 3'b000;
  logic [31:0] rs1E = '0;
  logic [31:0] rs2E = '0;
  logic        DivStallE, DivDoneE;
  logic [31:0] DivResultE;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2:0]  f3;
  logic [31:0] a, b;
  logic        seen;

  ex_div_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .DivStartE  (DivStartE),
    .FlushE     (FlushE),
    .funct3E    (funct3E),
    .rs1E       (rs1E),
    .rs2E       (rs2E),
    .DivStallE  (DivStallE),
    .DivDoneE   (DivDoneE),
    .DivResultE (DivResultE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // RISC-V M-extension semantics, including divide-by-zero and signed overflow.
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
    logic [31:0] q, r;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!op[0]) begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end else begin
      q = x / y;
      r = x % y;
    end
    return op[1] ? r : q;
  endfunction

  function automatic bit ref_fast(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    return (y == 32'd0) || (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  // Issue one divide, hold the start like a frozen D->E register, scramble operands after accept.
  task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    int          stalls;
    bit          done_seen;
    logic        stall_at_done;
    logic [31:0] res, exp_res;
    stalls        = 0;
    done_seen     = 1'b0;
    stall_at_done = 1'b0;
    res           = '0;
    exp_res       = ref_div(op, x, y);
    @(negedge clk);
    DivStartE = 1'b1;
    FlushE    = 1'b0;
    funct3E   = op;
    rs1E      = x;
    rs2E      = y;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (DivDoneE) begin
        done_seen     = 1'b1;
        res           = DivResultE;
        stall_at_done = DivStallE;
        break;
      end
      if (DivStallE) stalls++;
      @(negedge clk);
      rs1E = $urandom;
      rs2E = $urandom;
    end
    check("done_seen", 32'(done_seen), 32'd1);
    check("stall_cycles", 32'(stalls), ref_fast(op, x, y) ? 32'd1 : 32'(RUN_CYCLES + 1));
    check("stall_in_done", 32'(stall_at_done), 32'd0);
    check("result", res, exp_res);
    @(negedge clk);
    DivStartE = 1'b0;
    #1;
    check("done_pulse", 32'(DivDoneE), 32'd0);
    check("post_stall", 32'(DivStallE), 32'd0);
    check("result_hold", DivResultE, exp_res);
  endtask

  initial begin
    #2;
    check("rst_stall", 32'(DivStallE), 32'd0);
    check("rst_done", 32'(DivDoneE), 32'd0);
    check("rst_result", DivResultE, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Non-divide op on the start line must be ignored.
    DivStartE = 1'b1;
    funct3E   = 3'b000;
    rs1E      = 32'd100;
    rs2E      = 32'd7;
    #1;
    check("nondiv_stall", 32'(DivStallE), 32'd0);
    @(negedge clk);
    #1;
    check("nondiv_done", 32'(DivDoneE), 32'd0);
    DivStartE = 1'b0;

    do_op(3'b100, 32'd100, 32'd7);
    do_op(3'b110, 32'd100, 32'd7);
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2);
    do_op(3'b111, 32'hFFFF_FFF9, 32'd2);
    do_op(3'b101, 32'd5, 32'd0);
    do_op(3'b110, 32'd5, 32'd0);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush in the 10th RUN cycle: no stall that cycle, no result afterwards.
    @(negedge clk);
    DivStartE = 1'b1;
    funct3E   = 3'b100;
    rs1E      = 32'd1000;
    rs2E      = 32'd3;
    repeat (10) @(negedge clk);
    FlushE = 1'b1;
    #1;
    check("flush_stall", 32'(DivStallE), 32'd0);
    check("flush_done", 32'(DivDoneE), 32'd0);
    @(negedge clk);
    FlushE    = 1'b0;
    DivStartE = 1'b0;
    seen      = 1'b0;
    repeat (40) begin
      #1;
      if (DivDoneE || DivStallE) seen = 1'b1;
      @(negedge clk);
    end
    check("flush_quiet", 32'(seen), 32'd0);
    do_op(3'b101, 32'd20, 32'd3);

    // Asynchronous reset between clock edges while iterating.
    @(negedge clk);
    DivStartE = 1'b1;
    funct3E   = 3'b100;
    rs1E      = 32'd12345;
    rs2E      = 32'd7;
    repeat (5) @(negedge clk);
    #3;
    rst       = 1'b1;
    DivStartE = 1'b0;
    #1;
    check("arst_stall", 32'(DivStallE), 32'd0);
    check("arst_done", 32'(DivDoneE), 32'd0);
    check("arst_result", DivResultE, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    do_op(3'b100, 32'd9, 32'd3);

    for (int k = 0; k < 40; k++) begin
      f3 = 3'(4 + $urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      do_op(f3, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
